// File: rtl/ps2_keys_pkg.sv
// Shared types and constants for the PS/2 key tracker.
// Parser states, prefix bytes and the default key map.
package ps2_keys_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int DEF_NUM_KEYS = 16;

  // Slot i = {ext, code} at [9i+8:9i]; slot 15 first.
  localparam logic [DEF_NUM_KEYS*9-1:0] DEF_KEY_CODES = {
    9'h04D, 9'h02D, 9'h023, 9'h01B,
    9'h01C, 9'h01D, 9'h02C, 9'h02E,
    9'h025, 9'h026, 9'h01E, 9'h016,
    9'h174, 9'h172, 9'h16B, 9'h175
  };

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through event FIFO with occupancy
// and a sticky overflow flag for dropped pushes.
module ps2_event_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          valid,
  output logic [W-1:0]  data,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          ovf_clear
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          pop_ok;
  logic          push_ok;
  logic          drop;

  assign full    = (cnt == CW'(DEPTH));
  assign pop_ok  = pop & (cnt != '0);
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  assign valid    = (cnt != '0);
  assign data     = valid ? mem[rd_ptr] : '0;
  assign count    = cnt;

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (ovf_clear) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 make/break/extended parser with per-key held
// state and a queue of key events for the processor.
module ps2_key_tracker
  import ps2_keys_pkg::*;
#(
  parameter int NUM_KEYS   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES = DEF_KEY_CODES,
  parameter bit TYPEMATIC  = 1'b0,
  localparam int IW = idx_w(NUM_KEYS),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [7:0]          ps2_key_data,
  input  logic                ps2_key_pressed,
  output logic [NUM_KEYS-1:0] key_down,
  output logic                key_any,
  output logic                evt_valid,
  output logic [IW:0]         evt_data,
  input  logic                evt_ready,
  output logic [CW-1:0]       evt_count,
  output logic                overflow,
  input  logic                ovf_clear,
  output logic [7:0]          last_code
);

  ps2_state_e state;
  ps2_state_e state_nx;

  logic          code_vld;
  logic          code_mk;
  logic [8:0]    code;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          evt_push;
  logic [NUM_KEYS-1:0] key_down_nx;

  // Parser state and byte-derived registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      key_down  <= '0;
      last_code <= '0;
    end else begin
      state    <= state_nx;
      key_down <= key_down_nx;
      if (ps2_key_pressed) last_code <= ps2_key_data;
    end
  end

  // Next parser state and the completed code, if any.
  always_comb begin
    state_nx = state;
    code_vld = 1'b0;
    code_mk  = 1'b0;
    code     = '0;
    if (ps2_key_pressed) begin
      unique case (state)
        IDLE, EXT: begin
          unique case (1'b1)
            (ps2_key_data == PS2_EXT):
              state_nx = EXT;
            (ps2_key_data == PS2_BRK):
              state_nx = (state == EXT) ? EXT_BRK : BRK;
            default: begin
              state_nx = IDLE;
              code_vld = 1'b1;
              code_mk  = 1'b1;
              code     = {state == EXT, ps2_key_data};
            end
          endcase
        end
        BRK, EXT_BRK: begin
          state_nx = IDLE;
          code_vld = 1'b1;
          code     = {state == EXT_BRK, ps2_key_data};
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Key lookup; scanning downwards lets the lowest slot win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (code == KEY_CODES[9*i +: 9]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Held-state update and event push decision.
  always_comb begin
    key_down_nx = key_down;
    evt_push    = 1'b0;
    if (code_vld && hit) begin
      key_down_nx[hit_idx] = code_mk;
      evt_push = ~code_mk | ~key_down[hit_idx] | TYPEMATIC;
    end
  end

  assign key_any = |key_down;

  ps2_event_fifo #(
    .W     (IW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (evt_push),
    .push_data ({code_mk, hit_idx}),
    .pop       (evt_ready),
    .valid     (evt_valid),
    .data      (evt_data),
    .count     (evt_count),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomised and directed bench for ps2_key_tracker,
// one instance per typematic setting, against a queue model.
module tb_ps2_key_tracker;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] ps2_key_data = '0;
  logic       ps2_key_pressed = 1'b0;
  logic       evt_ready = 1'b0;
  logic       ovf_clear = 1'b0;

  logic [15:0] kd0, kd1;
  logic        any0, any1;
  logic        vld0, vld1;
  logic [4:0]  dat0, dat1;
  logic [3:0]  cnt0, cnt1;
  logic        ovf0, ovf1;
  logic [7:0]  lc0, lc1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ps2_key_tracker #(.TYPEMATIC(1'b0)) u_dut0 (
    .clock(clock), .resetn(resetn),
    .ps2_key_data(ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed),
    .key_down(kd0), .key_any(any0),
    .evt_valid(vld0), .evt_data(dat0),
    .evt_ready(evt_ready), .evt_count(cnt0),
    .overflow(ovf0), .ovf_clear(ovf_clear),
    .last_code(lc0)
  );

  ps2_key_tracker #(.TYPEMATIC(1'b1)) u_dut1 (
    .clock(clock), .resetn(resetn),
    .ps2_key_data(ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed),
    .key_down(kd1), .key_any(any1),
    .evt_valid(vld1), .evt_data(dat1),
    .evt_ready(evt_ready), .evt_count(cnt1),
    .overflow(ovf1), .ovf_clear(ovf_clear),
    .last_code(lc1)
  );

  // Reference model state
  int         codes [16] = '{'h175, 'h16B, 'h172, 'h174,
                             'h016, 'h01E, 'h026, 'h025,
                             'h02E, 'h02C, 'h01D, 'h01C,
                             'h01B, 'h023, 'h02D, 'h04D};
  bit         m_kd [16];
  logic [4:0] m_q0 [$];
  logic [4:0] m_q1 [$];
  bit         m_ovf0, m_ovf1;
  bit         m_ext, m_brk;
  logic [7:0] m_last;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_kd[k]) m_kd[k] = 1'b0;
    m_q0.delete();
    m_q1.delete();
    m_ovf0 = 1'b0;
    m_ovf1 = 1'b0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_last = '0;
  endtask

  task automatic model_step(input logic s, input logic [7:0] b,
                            input logic r, input logic c);
    bit   pop0, pop1, ev, mk, p0, drop0, drop1;
    int   idx;
    logic [8:0] code;
    logic [4:0] e;
    pop0 = r && m_q0.size() > 0;
    pop1 = r && m_q1.size() > 0;
    ev = 0; mk = 0; code = '0; idx = -1;
    drop0 = 0; drop1 = 0;
    if (s) begin
      m_last = b;
      if (m_brk) begin
        ev = 1; code = {m_ext, b};
        m_ext = 0; m_brk = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else if (b == 8'hE0) begin
        m_ext = 1;
      end else begin
        ev = 1; mk = 1; code = {m_ext, b};
        m_ext = 0;
      end
    end
    if (ev)
      for (int k = 0; k < 16; k++)
        if (idx < 0 && codes[k] == int'(code)) idx = k;
    if (pop0) void'(m_q0.pop_front());
    if (pop1) void'(m_q1.pop_front());
    if (idx >= 0) begin
      e  = {mk, 4'(idx)};
      p0 = !mk || !m_kd[idx];
      if (p0) begin
        if (m_q0.size() < 8) m_q0.push_back(e);
        else drop0 = 1;
      end
      if (m_q1.size() < 8) m_q1.push_back(e);
      else drop1 = 1;
      m_kd[idx] = mk;
    end
    if (c) m_ovf0 = 0; else if (drop0) m_ovf0 = 1;
    if (c) m_ovf1 = 0; else if (drop1) m_ovf1 = 1;
  endtask

  task automatic check_all();
    logic [15:0] kd;
    foreach (m_kd[k]) kd[k] = m_kd[k];
    chk("key_down0", 32'(kd0), 32'(kd));
    chk("key_down1", 32'(kd1), 32'(kd));
    chk("key_any0", 32'(any0), 32'(kd != 0));
    chk("key_any1", 32'(any1), 32'(kd != 0));
    chk("evt_valid0", 32'(vld0), 32'(m_q0.size() > 0));
    chk("evt_valid1", 32'(vld1), 32'(m_q1.size() > 0));
    chk("evt_data0", 32'(dat0),
        m_q0.size() > 0 ? 32'(m_q0[0]) : 32'd0);
    chk("evt_data1", 32'(dat1),
        m_q1.size() > 0 ? 32'(m_q1[0]) : 32'd0);
    chk("evt_count0", 32'(cnt0), 32'(m_q0.size()));
    chk("evt_count1", 32'(cnt1), 32'(m_q1.size()));
    chk("overflow0", 32'(ovf0), 32'(m_ovf0));
    chk("overflow1", 32'(ovf1), 32'(m_ovf1));
    chk("last_code0", 32'(lc0), 32'(m_last));
    chk("last_code1", 32'(lc1), 32'(m_last));
  endtask

  task automatic tick(input logic s, input logic [7:0] b,
                      input logic r, input logic c);
    @(negedge clock);
    ps2_key_pressed = s;
    ps2_key_data    = b;
    evt_ready       = r;
    ovf_clear       = c;
    model_step(s, b, r, c);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b, input logic r);
    tick(1'b1, b, r, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    resetn          = 1'b0;
    ps2_key_pressed = 1'b0;
    ps2_key_data    = '0;
    evt_ready       = 1'b0;
    ovf_clear       = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  logic [7:0] pool [20] = '{8'hE0, 8'hF0, 8'hE0, 8'hF0,
                            8'h1C, 8'h1D, 8'h1B, 8'h23,
                            8'h2D, 8'h4D, 8'h16, 8'h1E,
                            8'h26, 8'h25, 8'h2E, 8'h2C,
                            8'h75, 8'h6B, 8'h72, 8'h74};

  initial begin
    logic [7:0] mk9 [9] = '{8'h1C, 8'h1D, 8'h1B, 8'h23, 8'h2D,
                            8'h4D, 8'h16, 8'h1E, 8'h26};
    logic [7:0] b;
    model_reset();
    do_reset();

    send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
    drain(3);

    send(8'hE0, 0); send(8'h75, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    send(8'h75, 0);
    drain(3);

    send(8'h1D, 0); send(8'h1D, 0); send(8'h1D, 0);
    drain(4);
    send(8'hF0, 1); send(8'h1D, 1);
    drain(2);

    do_reset();
    foreach (mk9[i]) send(mk9[i], 0);
    send(8'hF0, 0);
    send(8'h1C, 1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    drain(10);

    send(8'hE0, 0); send(8'hF0, 0);
    do_reset();
    send(8'h75, 0);
    drain(2);

    send(8'hE0, 0); send(8'hAA, 0); send(8'hFA, 0);
    send(8'h16, 0);
    drain(2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      if ($urandom_range(0, 9) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 19)];
      tick($urandom_range(0, 9) < 7, b,
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
